// File: rtl/dly_tap_cal.sv
// Delay-line tap calibration controller.
// Sweeps a 16-tap variable delay line through every tap using single-cycle
// increment pulses. At each tap it compares the delayed signal with the
// training reference and records pass/fail. It then moves the delay line to
// the centre of the widest contiguous passing window.
// The delay line shares clk/rst with this block, so a tap mirror tracks the
// delay line exactly without any read-back path.
module dly_tap_cal #(
  parameter int unsigned SETTLE = 4,   // cycles waited after a tap change (1..255)
  parameter int unsigned DWELL  = 32   // compare cycles per tap (1..65535)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        dly_sig,
  input  logic        ref_sig,
  output logic        inc_pulse,
  output logic        busy,
  output logic        done,
  output logic        fail,
  output logic [15:0] pass_map,
  output logic [3:0]  sel_tap
);

  // Controller states
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REWIND  = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_MEASURE = 3'd3;
  localparam logic [2:0] S_ADVANCE = 3'd4;
  localparam logic [2:0] S_EVAL    = 3'd5;
  localparam logic [2:0] S_STEP    = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  // Terminal counts for the shared phase counter
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);
  localparam logic [15:0] DWELL_LAST  = 16'(DWELL - 1);
  localparam logic [15:0] EVAL_LAST   = 16'd15;

  // State registers
  logic [2:0]  state_q,      state_d;
  logic [3:0]  cur_tap_q,    cur_tap_d;
  logic        inc_pulse_q,  inc_pulse_d;
  logic        busy_q,       busy_d;
  logic        done_q,       done_d;
  logic        fail_q,       fail_d;
  logic [15:0] pass_map_q,   pass_map_d;
  logic [3:0]  sel_tap_q,    sel_tap_d;
  logic [15:0] cnt_q,        cnt_d;
  logic        mismatch_q,   mismatch_d;
  logic [3:0]  run_start_q,  run_start_d;
  logic [4:0]  run_len_q,    run_len_d;
  logic [3:0]  best_start_q, best_start_d;
  logic [4:0]  best_len_q,   best_len_d;

  // Window scan helpers (valid while in EVAL)
  logic [3:0]  tap_nxt;
  logic [3:0]  eval_idx;
  logic        eval_bit;
  logic [3:0]  scan_run_start;
  logic [4:0]  scan_run_len;
  logic [3:0]  scan_best_start;
  logic [4:0]  scan_best_len;
  logic [4:0]  half_len;
  logic [3:0]  sel_calc;
  logic        fail_calc;

  // Tap the delay line will hold after this edge: a pulse presented this
  // cycle is taken by the delay line at the same edge as by the mirror.
  always_comb begin
    tap_nxt = cur_tap_q + {3'b000, inc_pulse_q};
  end

  // Longest-run scan of pass_map, one bit per EVAL cycle; strict '>' keeps
  // the earliest window on a tie.
  always_comb begin
    eval_idx        = cnt_q[3:0];
    eval_bit        = pass_map_q[eval_idx];
    scan_run_start  = run_start_q;
    scan_run_len    = 5'd0;
    scan_best_start = best_start_q;
    scan_best_len   = best_len_q;
    if (eval_bit) begin
      scan_run_len = run_len_q + 5'd1;
      if (run_len_q == 5'd0) begin
        scan_run_start = eval_idx;
      end
    end
    if (scan_run_len > best_len_q) begin
      scan_best_start = scan_run_start;
      scan_best_len   = scan_run_len;
    end
    fail_calc = (scan_best_len == 5'd0);
    half_len  = (scan_best_len - 5'd1) >> 1;
    sel_calc  = fail_calc ? 4'd0 : (scan_best_start + half_len[3:0]);
  end

  // Next-state logic for the whole controller.
  // NOTE: every variable gets a default at the top of the block so that no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d      = state_q;
    cur_tap_d    = tap_nxt;
    inc_pulse_d  = 1'b0;
    fail_d       = fail_q;
    pass_map_d   = pass_map_q;
    sel_tap_d    = sel_tap_q;
    cnt_d        = cnt_q;
    mismatch_d   = mismatch_q;
    run_start_d  = run_start_q;
    run_len_d    = run_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_REWIND;
          pass_map_d  = 16'h0000;
          inc_pulse_d = (tap_nxt != 4'd0);
        end
      end

      // Step forward until the delay line wraps back to tap 0.
      S_REWIND: begin
        if (tap_nxt == 4'd0) begin
          state_d = S_SETTLE;
          cnt_d   = 16'd0;
        end else begin
          inc_pulse_d = 1'b1;
        end
      end

      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d    = S_MEASURE;
          cnt_d      = 16'd0;
          mismatch_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      // Any single miscompare in the dwell window fails the tap.
      S_MEASURE: begin
        mismatch_d = mismatch_q | (dly_sig ^ ref_sig);
        if (cnt_q == DWELL_LAST) begin
          state_d     = S_ADVANCE;
          inc_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      // Record the tap just measured while its pulse moves to the next one.
      S_ADVANCE: begin
        pass_map_d[cur_tap_q] = ~mismatch_q;
        cnt_d                 = 16'd0;
        if (cur_tap_q == 4'd15) begin
          state_d      = S_EVAL;
          run_start_d  = 4'd0;
          run_len_d    = 5'd0;
          best_start_d = 4'd0;
          best_len_d   = 5'd0;
        end else begin
          state_d = S_SETTLE;
        end
      end

      S_EVAL: begin
        run_start_d  = scan_run_start;
        run_len_d    = scan_run_len;
        best_start_d = scan_best_start;
        best_len_d   = scan_best_len;
        if (cnt_q == EVAL_LAST) begin
          state_d     = S_STEP;
          sel_tap_d   = sel_calc;
          fail_d      = fail_calc;
          inc_pulse_d = (sel_calc != 4'd0);
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      // The sweep left the delay line at tap 0; walk it up to sel_tap.
      S_STEP: begin
        if (tap_nxt == sel_tap_q) begin
          state_d = S_DONE;
        end else begin
          inc_pulse_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers; reset aborts any calibration in progress.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cur_tap_q    <= 4'd0;
      inc_pulse_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      pass_map_q   <= 16'h0000;
      sel_tap_q    <= 4'd0;
      cnt_q        <= 16'd0;
      mismatch_q   <= 1'b0;
      run_start_q  <= 4'd0;
      run_len_q    <= 5'd0;
      best_start_q <= 4'd0;
      best_len_q   <= 5'd0;
    end else begin
      state_q      <= state_d;
      cur_tap_q    <= cur_tap_d;
      inc_pulse_q  <= inc_pulse_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      pass_map_q   <= pass_map_d;
      sel_tap_q    <= sel_tap_d;
      cnt_q        <= cnt_d;
      mismatch_q   <= mismatch_d;
      run_start_q  <= run_start_d;
      run_len_q    <= run_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
    end
  end

  assign inc_pulse = inc_pulse_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign pass_map  = pass_map_q;
  assign sel_tap   = sel_tap_q;

endmodule

// File: tb/tb_dly_tap_cal.sv
// Self-checking bench for dly_tap_cal.
// Two instances: one with default timing, one with SETTLE=DWELL=1. Each is
// wired to a behavioural 16-tap delay line fed by a random bit stream; the
// reference signal agrees with the delayed stream only on taps chosen to pass.
module tb_dly_tap_cal;

  localparam int S0 = 4;
  localparam int D0 = 32;
  localparam int S1 = 1;
  localparam int D1 = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        start_v    [2];
  logic        dly_v      [2];
  logic        ref_v      [2];
  logic        inc_v      [2];
  logic        busy_v     [2];
  logic        done_v     [2];
  logic        fail_v     [2];
  logic [15:0] map_v      [2];
  logic [3:0]  sel_v      [2];

  // Behavioural delay-line models
  logic [15:0] hist = 16'h0000;      // hist[k] = source bit k cycles ago
  logic [3:0]  model_tap [2];
  logic [15:0] pass_set  [2];

  int cyc = 0;
  int pulse_cnt [2];
  int pulse_at  [2][1024];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dly_tap_cal #(.SETTLE(S0), .DWELL(D0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .dly_sig(dly_v[0]), .ref_sig(ref_v[0]),
    .inc_pulse(inc_v[0]), .busy(busy_v[0]), .done(done_v[0]), .fail(fail_v[0]),
    .pass_map(map_v[0]), .sel_tap(sel_v[0])
  );

  dly_tap_cal #(.SETTLE(S1), .DWELL(D1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .dly_sig(dly_v[1]), .ref_sig(ref_v[1]),
    .inc_pulse(inc_v[1]), .busy(busy_v[1]), .done(done_v[1]), .fail(fail_v[1]),
    .pass_map(map_v[1]), .sel_tap(sel_v[1])
  );

  assign dly_v[0] = hist[model_tap[0]];
  assign dly_v[1] = hist[model_tap[1]];
  assign ref_v[0] = pass_set[0][model_tap[0]] ? dly_v[0] : ~dly_v[0];
  assign ref_v[1] = pass_set[1][model_tap[1]] ? dly_v[1] : ~dly_v[1];

  // Delay lines: reset with the controller, step +1 (wrapping) per pulse.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_tap[0] <= 4'd0;
      model_tap[1] <= 4'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (inc_v[i] === 1'b1) model_tap[i] <= model_tap[i] + 4'd1;
      end
    end
  end

  // Source stream and cycle counter.
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    hist <= {hist[14:0], 1'($urandom_range(0, 1))};
  end

  // Log the cycle of every increment pulse.
  initial begin
    pulse_cnt[0] = 0;
    pulse_cnt[1] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (inc_v[i] === 1'b1 && pulse_cnt[i] < 1024) begin
          pulse_at[i][pulse_cnt[i]] = cyc;
          pulse_cnt[i] = pulse_cnt[i] + 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference selection by brute force over every candidate window.
  function automatic void ref_select(input logic [15:0] m, output logic [3:0] sel,
                                     output logic fl);
    int best_len;
    int best_s;
    best_len = 0;
    best_s   = 0;
    for (int s = 0; s < 16; s++) begin
      for (int e = s; e < 16; e++) begin
        bit all_pass;
        all_pass = 1'b1;
        for (int k = s; k <= e; k++) if (!m[k]) all_pass = 1'b0;
        if (all_pass && (e - s + 1) > best_len) begin
          best_len = e - s + 1;
          best_s   = s;
        end
      end
    end
    fl  = (best_len == 0);
    sel = fl ? 4'd0 : 4'(best_s + (best_len - 1) / 2);
  endfunction

  // One full calibration on instance i; called and returning on a negedge.
  task automatic run_cal(input int i, input logic [15:0] set, input bit stray, input string name);
    int s_p, d_p, base, c0, n, nrew, nrew_exp, waited, settle_entry, idx16;
    logic [3:0] exp_sel;
    logic       exp_fail;
    s_p = (i == 0) ? S0 : S1;
    d_p = (i == 0) ? D0 : D1;
    pass_set[i] = set;
    ref_select(set, exp_sel, exp_fail);
    nrew_exp = (16 - int'(model_tap[i])) % 16;

    check({name, "_busy_pre"}, 32'(busy_v[i]), 32'd0);
    base = pulse_cnt[i];
    c0   = cyc;
    start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
    check({name, "_busy_post"}, 32'(busy_v[i]), 32'd1);
    check({name, "_done_drop"}, 32'(done_v[i]), 32'd0);
    check({name, "_map_clr"},   32'(map_v[i]),  32'd0);

    waited = 0;
    while (done_v[i] !== 1'b1 && waited < 3000) begin
      @(negedge clk);
      waited++;
      start_v[i] = (stray && (waited == 40 || waited == 300));
    end
    start_v[i] = 1'b0;
    check({name, "_done_in_time"}, 32'(waited < 3000), 32'd1);

    n = pulse_cnt[i] - base;
    nrew = 0;
    for (int k = 0; k < n; k++) begin
      if (nrew == k && pulse_at[i][base + k] == c0 + 1 + k) nrew++;
    end
    check({name, "_rewind_pulses"}, 32'(nrew), 32'(nrew_exp));
    check({name, "_total_pulses"},  32'(n),    32'(nrew_exp + 16 + int'(exp_sel)));

    settle_entry = c0 + 1 + ((nrew_exp > 0) ? nrew_exp : 1);
    idx16 = base + nrew_exp + 15;
    check({name, "_sweep_cycles"}, 32'(pulse_at[i][idx16] + 1 - settle_entry),
          32'(16 * (s_p + d_p + 1)));

    check({name, "_done"},     32'(done_v[i]),     32'd1);
    check({name, "_busy_end"}, 32'(busy_v[i]),     32'd0);
    check({name, "_fail"},     32'(fail_v[i]),     32'(exp_fail));
    check({name, "_pass_map"}, 32'(map_v[i]),      32'(set));
    check({name, "_sel_tap"},  32'(sel_v[i]),      32'(exp_sel));
    check({name, "_line_tap"}, 32'(model_tap[i]),  32'(exp_sel));
  endtask

  initial begin
    int base, waited;
    logic [15:0] r;
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    pass_set[0] = 16'hFFFF;
    pass_set[1] = 16'hFFFF;

    // Power-on reset
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst%0d_inc", i),  32'(inc_v[i]),  32'd0);
      check($sformatf("rst%0d_busy", i), 32'(busy_v[i]), 32'd0);
      check($sformatf("rst%0d_done", i), 32'(done_v[i]), 32'd0);
      check($sformatf("rst%0d_fail", i), 32'(fail_v[i]), 32'd0);
      check($sformatf("rst%0d_map", i),  32'(map_v[i]),  32'd0);
      check($sformatf("rst%0d_sel", i),  32'(sel_v[i]),  32'd0);
    end
    #2 rst = 1'b0;
    @(negedge clk);

    // Directed windows, then restart-from-DONE cases and randomized maps
    run_cal(0, 16'h03E0, 1'b0, "win5_9");
    run_cal(0, 16'h1C0E, 1'b1, "tie");
    run_cal(0, 16'hFFFF, 1'b0, "all");
    run_cal(0, 16'h0000, 1'b0, "none");
    run_cal(0, 16'h8001, 1'b0, "edges");
    for (int k = 0; k < 2; k++) begin
      r = 16'($urandom);
      run_cal(0, r, 1'b0, $sformatf("rnd%0d", k));
    end

    // Abort with reset while measuring tap 6
    run_cal(0, 16'h0000, 1'b0, "pre_abort");
    pass_set[0] = 16'h00F0;
    base = pulse_cnt[0];
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    waited = 0;
    while (pulse_cnt[0] - base < 6 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    check("abort_reach_tap6", 32'(waited < 3000), 32'd1);
    repeat (S0 + 3) @(negedge clk);
    check("abort_tap_before", 32'(model_tap[0]), 32'd6);
    check("abort_busy_before", 32'(busy_v[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_inc",  32'(inc_v[0]),  32'd0);
    check("abort_busy", 32'(busy_v[0]), 32'd0);
    check("abort_done", 32'(done_v[0]), 32'd0);
    check("abort_fail", 32'(fail_v[0]), 32'd0);
    check("abort_map",  32'(map_v[0]),  32'd0);
    check("abort_sel",  32'(sel_v[0]),  32'd0);
    base = pulse_cnt[0];
    repeat (5) @(negedge clk);
    check("abort_no_pulses", 32'(pulse_cnt[0] - base), 32'd0);
    #2 rst = 1'b0;
    @(negedge clk);
    run_cal(0, 16'h0FF0, 1'b0, "post_abort");

    // Short-timing instance: 16*(1+1+1) = 48-cycle sweep
    run_cal(1, 16'h03E0, 1'b0, "fast");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dly_tap_cal.md
Name: dly_tap_cal

Overview:
- Calibration controller that sits directly upstream of the 16-tap variable delay line (0..15 cycles, one-cycle inc_pulse steps the tap +1, wrapping 15->0).
- On start it sweeps all 16 taps by issuing inc_pulse. At each tap it compares the delay output against an expected training pattern and records pass/fail per tap.
- It then steps the delay line to the centre of the widest passing window.
- The delay line and this block share clk/rst, so both begin at tap 0 after reset.

Parameters:
- SETTLE, 4, cycles waited after each tap change before comparing (1..255).
- DWELL, 32, compare cycles per tap (1..65535).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; accepted only in IDLE or DONE.
- dly_sig  in  1  out_sig of the delay line.
- ref_sig  in  1  expected value of dly_sig on the same cycle, from the pattern checker.
- inc_pulse  out  1  registered; drives the delay line's inc_pulse.
- busy  out  1  high from the cycle after start acceptance until DONE is entered.
- done  out  1  high in DONE, cleared on the cycle after the next start is accepted.
- fail  out  1  valid with done; 1 = no tap passed.
- pass_map  out  16  bit i = tap i passed; valid with done.
- sel_tap  out  4  chosen tap; valid with done.

Behaviour:
- Reset (async) state:
  - state = IDLE.
  - inc_pulse, busy, done, fail = 0; pass_map = 0; sel_tap = 0.
  - Internal tap mirror cur_tap = 0.
  - Reset mid-operation aborts immediately; inc_pulse is 0 from reset assertion.
- cur_tap tracking:
  - cur_tap increments (mod 16) on every cycle inc_pulse=1.
  - cur_tap always equals the delay line's tap.
- States and transitions:
  - IDLE: start=1 -> REWIND.
  - REWIND: issue one inc_pulse per cycle until cur_tap==0. The count is (16-cur_tap) mod 16, so 0 pulses if cur_tap is already 0. Then -> SETTLE. pass_map is cleared on entry.
  - SETTLE: inc_pulse=0 for SETTLE cycles, then -> MEASURE.
  - MEASURE: for DWELL cycles, set a sticky mismatch flag when dly_sig != ref_sig. The flag clears on entry. Then -> ADVANCE.
  - ADVANCE: one cycle with inc_pulse=1, and pass_map[cur_tap] <= ~mismatch. If cur_tap was 15 (delay wraps to 0) -> EVAL, else -> SETTLE.
  - EVAL: scan pass_map bit 0..15, one bit per cycle (exactly 16 cycles). Then -> STEP.
  - STEP: issue sel_tap pulses, one per cycle (0 pulses if sel_tap==0 or fail). Then -> DONE.
  - DONE: busy=0, done=1; start=1 -> REWIND.
- Start handling: start is ignored in all states other than IDLE/DONE.
- Selection rule:
  - Pick the longest contiguous run of 1s in pass_map, non-circular (tap 15 and tap 0 are not adjacent).
  - Tie -> lowest start index.
  - sel_tap = start + floor((len-1)/2).
  - No passing tap -> fail=1, sel_tap=0.
- inc_pulse never asserts outside REWIND, ADVANCE and STEP.
- Sweep timing: exactly 16*(SETTLE+DWELL+1) cycles from SETTLE entry to EVAL entry. This is 592 cycles at defaults.

Test Plan:
- Bench model (all scenarios): behavioural 16-tap delay, with ref_sig chosen per tap so the listed taps pass.
- Reset then start, taps 5..9 pass -> exactly 16 sweep pulses + 7 step pulses; done=1, pass_map=0x03E0, sel_tap=7, fail=0; bench delay model ends at tap 7.
- Taps 1..3 and 10..12 pass (tie) -> pass_map=0x1C0E, sel_tap=2; 2 step pulses.
- All taps pass -> pass_map=0xFFFF, sel_tap=7. No taps pass -> fail=1, sel_tap=0; 16 total pulses only, delay back at tap 0.
- Restart from DONE with sel_tap=7 -> 9 REWIND pulses precede the first SETTLE; done drops the cycle after start; start pulses during busy have no effect.
- Assert rst mid-MEASURE at tap 6 -> all outputs 0 immediately, no further inc_pulse. After release (delay line also reset), start -> 0 REWIND pulses and a normal sweep; run with DWELL=1, SETTLE=1 checks 48-cycle sweep.
